// File: rtl/fxp_seq_divider_pkg.sv
// Shared definitions for the sequential fixed-point divider.
// Contents:
//   WIDTH / FRAC   operand width and fractional bit count (Q1.15 default)
//   QW / CNT_W     quotient length and iteration-counter width
//   QMAX / QMIN    saturation limits of the Q format
//   state_e        control FSM states
//   abs_val        two's complement magnitude (the most negative value maps to itself)
package fxp_seq_divider_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 15;
  localparam int QW    = WIDTH + FRAC;
  localparam int CNT_W = $clog2(QW + 1);

  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // Reading the result as unsigned keeps |0x8000| = 0x8000 representable.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/fxp_seq_divider_if.sv
// Start/done handshake bundle shared by the DCT divider and multiplier.
// Signals:
//   A, B   dividend / divisor (Q1.FRAC, two's complement)
//   start  request, taken only while the unit is idle
//   R      quotient, held from done until the next accepted start
//   done   one-cycle completion pulse
//   busy   operation in flight
//   ovf    result saturated
//   dz     divide by zero
// Modports: master drives operands and start; slave (the divider) drives results.
interface fxp_seq_divider_if;
  import fxp_seq_divider_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             start;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             busy;
  logic             ovf;
  logic             dz;

  modport master (
    output A, B, start,
    input  R, done, busy, ovf, dz
  );

  modport slave (
    input  A, B, start,
    output R, done, busy, ovf, dz
  );

endinterface

// File: rtl/fxp_seq_divider_datapath.sv
// Datapath of the radix-2 restoring divider.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture operand magnitudes and signs, clear the remainder, arm the counter
//   step         produce one quotient bit
//   fix          apply the sign and saturation, then update r/ovf/dz
//   a, b         raw operands
//   count_zero   all quotient bits have been produced
//   r, ovf, dz   registered results
module fxp_seq_divider_datapath
  import fxp_seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             count_zero,
  output logic [WIDTH-1:0] r,
  output logic             ovf,
  output logic             dz
);

  logic [QW-1:0]    dvd_q, dvd_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sign_q, sign_d;
  logic             sign_a_q, sign_a_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   rem_shift;

  always_comb begin
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    count_d   = count_q;
    sign_d    = sign_q;
    sign_a_d  = sign_a_q;
    dz_pend_d = dz_pend_q;
    r_d       = r_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    // The next dividend bit enters from the MSB of the |A|<<FRAC shift register.
    rem_shift = {rem_q, dvd_q[QW-1]};

    if (load) begin
      dvd_d     = {abs_val(a), {FRAC{1'b0}}};
      quo_d     = '0;
      rem_d     = '0;
      div_d     = abs_val(b);
      count_d   = CNT_W'(QW);
      sign_d    = a[WIDTH-1] ^ b[WIDTH-1];
      sign_a_d  = a[WIDTH-1];
      dz_pend_d = (b == '0);
    end else if (step) begin
      dvd_d   = {dvd_q[QW-2:0], 1'b0};
      count_d = count_q - 1'b1;
      // The remainder stays below |B| <= 2^(WIDTH-1), so the difference fits in WIDTH bits.
      if (rem_shift >= {1'b0, div_q}) begin
        rem_d = WIDTH'(rem_shift - {1'b0, div_q});
        quo_d = {quo_q[QW-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[QW-2:0], 1'b0};
      end
    end else if (fix) begin
      dz_d = dz_pend_q;
      if (dz_pend_q) begin
        r_d   = sign_a_q ? QMIN : QMAX;
        ovf_d = 1'b0;
      end else if (!sign_q) begin
        if (quo_q > QW'(QMAX)) begin
          r_d   = QMAX;
          ovf_d = 1'b1;
        end else begin
          r_d   = quo_q[WIDTH-1:0];
          ovf_d = 1'b0;
        end
      end else begin
        // A negative result can reach 2^(WIDTH-1) exactly before it saturates.
        if (quo_q > QW'(QMIN)) begin
          r_d   = QMIN;
          ovf_d = 1'b1;
        end else begin
          r_d   = ~quo_q[WIDTH-1:0] + 1'b1;
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      sign_a_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      sign_a_q  <= sign_a_d;
      dz_pend_q <= dz_pend_d;
      r_q       <= r_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign count_zero = (count_q == '0);
  assign r          = r_q;
  assign ovf        = ovf_q;
  assign dz         = dz_q;

endmodule

// File: rtl/fxp_seq_divider.sv
// Sequential signed Q1.FRAC divider, R = A / B, one quotient bit per clock.
// It uses the same start/done handshake as the DCT multiplier, so either unit
// can sit behind the same controller.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    fxp_seq_divider_if slave (A, B, start in; R, done, busy, ovf, dz out)
// The FSM is IDLE -> DIV -> FIX -> DONE -> IDLE. Once a start is accepted,
// done rises WIDTH+FRAC+2 clocks later, whatever the operands are.
module fxp_seq_divider
  import fxp_seq_divider_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fxp_seq_divider_if.slave  bus
);

  state_e state_q;
  logic   done_q;
  logic   busy_q;
  logic   count_zero;
  logic   load;
  logic   step;
  logic   fix;

  assign load = (state_q == ST_IDLE) && bus.start;
  assign step = (state_q == ST_DIV) && !count_zero;
  assign fix  = (state_q == ST_FIX);

  // DIV spends one final cycle observing count==0 before it moves to FIX.
  // That cycle sets the fixed latency of WIDTH+FRAC+2 clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_DIV;
            busy_q  <= 1'b1;
          end
        end
        ST_DIV: begin
          if (count_zero) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.busy = busy_q;

  fxp_seq_divider_datapath u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .fix        (fix),
    .a          (bus.A),
    .b          (bus.B),
    .count_zero (count_zero),
    .r          (bus.R),
    .ovf        (bus.ovf),
    .dz         (bus.dz)
  );

endmodule
